sseg_scan_controller: RTL and testbench

Parametrised multiplexed seven-segment digit scanner that replaces the fixed 4-digit combinational anode decode. It contains its own refresh timebase and drives one-hot anodes with:
- a configurable digit count
- a dead-time (anti-ghosting) blank interval between digits
- 16-level PWM brightness
- per-digit blanking

It also exports the active digit index and a frame marker, so the segment/data mux can stay in step with the scan.

---
 rtl/sseg_scan_controller.sv | 160 ++++++++++++++++
 tb/tb_sseg_scan_controller.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_scan_controller
//  Description : Multiplexed seven-segment digit scanner with its own refresh
//                timebase. Each digit gets a slot of CLK_DIV cycles. A slot
//                is a blanking interval with all anodes off, then a
//                PWM-controlled lit interval, then off for the rest of the
//                slot.
//  Ports       : clk_i         system clock
//                reset_i       asynchronous active-high reset
//                enable_i      scan enable; low blanks the anodes and restarts
//                digit_en_i    per-digit enable (dark digits keep their slot)
//                brightness_i  PWM level 0..15, sampled at each slot start
//                anode_o       registered one-hot anode drive
//                digit_sel_o   registered index of the current slot
//                frame_start_o one-cycle pulse at the first cycle of slot 0
//  Revision    : 1.0 - initial release
// ============================================================================
module sseg_scan_controller #(
   parameter int NUM_DIGITS       = 4,
   parameter int CLK_DIV          = 100000,
   parameter int BLANK_CYCLES     = 16,
   parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          enable_i,
   input  logic [NUM_DIGITS-1:0]         digit_en_i,
   input  logic [3:0]                    brightness_i,
   output logic [NUM_DIGITS-1:0]         anode_o,
   output logic [$clog2(NUM_DIGITS)-1:0] digit_sel_o,
   output logic                          frame_start_o
);

   localparam int SEL_W   = $clog2(NUM_DIGITS);
   localparam int CNT_W   = $clog2(CLK_DIV);
   localparam int ON_UNIT = (CLK_DIV - BLANK_CYCLES) / 16;

   localparam logic [CNT_W-1:0]      C_CNT_LAST   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0]      C_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [SEL_W-1:0]      C_SEL_LAST   = SEL_W'(NUM_DIGITS - 1);
   // XOR mask turning a one-hot "lit" vector into the pin polarity; it is
   // also the all-inactive anode pattern.
   localparam logic [NUM_DIGITS-1:0] C_ANODE_OFF  =
      ANODE_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BLANK = 2'd1,
      S_ON    = 2'd2,
      S_OFF   = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [SEL_W-1:0]        slot_q, slot_d;
   logic [3:0]              bright_q, bright_d;
   logic [NUM_DIGITS-1:0]   anode_q, anode_d;
   logic [SEL_W-1:0]        digit_sel_q, digit_sel_d;
   logic                    frame_start_q, frame_start_d;

   logic [3:0]              w_bright_cur;
   logic [31:0]             w_on_last;
   logic                    w_on_end;
   logic                    w_slot_first;
   logic [SEL_W-1:0]        w_slot_next;
   logic [NUM_DIGITS-1:0]   w_onehot;

   // On the first cycle of a slot the live input is used directly so that
   // the level in force for the whole slot is the one sampled right there.
   assign w_slot_first = (state_q == S_BLANK) && (cnt_q == '0);
   assign w_bright_cur = w_slot_first ? brightness_i : bright_q;
   assign w_on_last    = 32'(BLANK_CYCLES) - 32'd1
                       + 32'(ON_UNIT) * (32'(w_bright_cur) + 32'd1);
   assign w_on_end     = (32'(cnt_q) == w_on_last);
   assign w_slot_next  = (slot_q == C_SEL_LAST) ? '0 : slot_q + SEL_W'(1);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      slot_d   = slot_q;
      bright_d = bright_q;
      w_onehot = '0;

      if (!enable_i) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         slot_d  = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               state_d = S_BLANK;
               cnt_d   = '0;
               slot_d  = '0;
            end
            S_BLANK: begin
               if (w_slot_first) bright_d = brightness_i;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == C_BLANK_LAST) state_d = S_ON;
            end
            S_ON: begin
               w_onehot[slot_q] = digit_en_i[slot_q];
               if (w_on_end && (cnt_q == C_CNT_LAST)) begin
                  // Full brightness filled the slot exactly: no OFF phase.
                  state_d = S_BLANK;
                  cnt_d   = '0;
                  slot_d  = w_slot_next;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
                  if (w_on_end) state_d = S_OFF;
               end
            end
            S_OFF: begin
               if (cnt_q == C_CNT_LAST) begin
                  state_d = S_BLANK;
                  cnt_d   = '0;
                  slot_d  = w_slot_next;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
               slot_d  = '0;
            end
         endcase
      end

      anode_d       = w_onehot ^ C_ANODE_OFF;
      digit_sel_d   = enable_i ? slot_q : '0;
      frame_start_d = enable_i && w_slot_first && (slot_q == '0);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         slot_q        <= '0;
         bright_q      <= '0;
         anode_q       <= C_ANODE_OFF;
         digit_sel_q   <= '0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         slot_q        <= slot_d;
         bright_q      <= bright_d;
         anode_q       <= anode_d;
         digit_sel_q   <= digit_sel_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign anode_o       = anode_q;
   assign digit_sel_o   = digit_sel_q;
   assign frame_start_o = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sseg_scan_controller
//  Description : Directed self-checking bench. One 4-digit active-low
//                instance (CLK_DIV=40, BLANK_CYCLES=8) and one 8-digit
//                active-high instance (CLK_DIV=24, BLANK_CYCLES=4) share
//                clock, reset, enable and brightness.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sseg_scan_controller;

   logic       clk;
   logic       rst;
   logic       enable;
   logic [3:0] digit_en;
   logic [7:0] digit_en8;
   logic [3:0] brightness;
   logic [3:0] anode4;
   logic [1:0] sel4;
   logic       fs4;
   logic [7:0] anode8;
   logic [2:0] sel8;
   logic       fs8;

   int n_vec = 0;
   int n_err = 0;
   int m_sb  = 15;   // brightness latched at the current 4-digit slot start

   sseg_scan_controller #(
      .NUM_DIGITS(4), .CLK_DIV(40), .BLANK_CYCLES(8), .ANODE_ACTIVE_LOW(1'b1)
   ) dut (
      .clk_i(clk), .reset_i(rst), .enable_i(enable), .digit_en_i(digit_en),
      .brightness_i(brightness), .anode_o(anode4), .digit_sel_o(sel4),
      .frame_start_o(fs4)
   );

   sseg_scan_controller #(
      .NUM_DIGITS(8), .CLK_DIV(24), .BLANK_CYCLES(4), .ANODE_ACTIVE_LOW(1'b0)
   ) dut8 (
      .clk_i(clk), .reset_i(rst), .enable_i(enable), .digit_en_i(digit_en8),
      .brightness_i(brightness), .anode_o(anode8), .digit_sel_o(sel8),
      .frame_start_o(fs8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Never more than one lit anode, on either instance, on any cycle.
   always @(negedge clk) begin
      if (!rst) begin
         n_vec = n_vec + 2;
         if (!$onehot0(~anode4)) begin
            n_err = n_err + 1;
            $display("FAIL onehot4 t=%0t anode=%b required at most one 0", $time, anode4);
         end
         if (!$onehot0(anode8)) begin
            n_err = n_err + 1;
            $display("FAIL onehot8 t=%0t anode=%b required at most one 1", $time, anode8);
         end
      end
   end

   // Expected 4-digit anode for frame cycle i: 8 blank, 2*(b+1) lit, rest off.
   function automatic logic [3:0] exp_anode4(input int i, input int sb, input logic [3:0] en);
      int k;
      int s;
      k = i % 40;
      s = (i / 40) % 4;
      if (k >= 8 && k < 8 + 2 * (sb + 1) && en[s]) return ~(4'b0001 << s);
      return 4'hF;
   endfunction

   // Drop enable, load new inputs, re-enable; the next negedge is frame cycle 0.
   task automatic restart(input logic [3:0] b, input logic [3:0] en);
      enable = 1'b0;
      @(negedge clk);
      brightness = b;
      digit_en   = en;
      enable     = 1'b1;
      @(negedge clk);
   endtask

   // Checks frame cycles first..first+n-1 of the 4-digit instance; after
   // checking cycle chg_i the brightness/digit_en inputs are changed.
   task automatic run_scan(input int first, input int n, input int chg_i,
                           input logic [3:0] chg_b, input logic [3:0] chg_en,
                           input string tag);
      logic [3:0] ea;
      for (int i = first; i < first + n; i++) begin
         @(negedge clk);
         if (i % 40 == 0) m_sb = int'(brightness);
         ea = exp_anode4(i, m_sb, digit_en);
         n_vec = n_vec + 3;
         if (anode4 !== ea) begin
            n_err = n_err + 1;
            $display("FAIL %s anode cyc=%0d got=%b exp=%b", tag, i, anode4, ea);
         end
         if (sel4 !== 2'((i / 40) % 4)) begin
            n_err = n_err + 1;
            $display("FAIL %s digit_sel cyc=%0d got=%0d exp=%0d", tag, i, sel4, (i / 40) % 4);
         end
         if (fs4 !== (i % 160 == 0)) begin
            n_err = n_err + 1;
            $display("FAIL %s frame_start cyc=%0d got=%b exp=%b", tag, i, fs4, (i % 160 == 0));
         end
         if (i == chg_i) begin
            brightness = chg_b;
            digit_en   = chg_en;
         end
      end
   endtask

   task automatic test_reset();
      n_vec = n_vec + 6;
      if (anode4 !== 4'hF) begin
         n_err = n_err + 1; $display("FAIL reset_anode4 got=%b exp=1111", anode4);
      end
      if (sel4 !== 2'd0) begin
         n_err = n_err + 1; $display("FAIL reset_sel4 got=%0d exp=0", sel4);
      end
      if (fs4 !== 1'b0) begin
         n_err = n_err + 1; $display("FAIL reset_fs4 got=%b exp=0", fs4);
      end
      if (anode8 !== 8'h00) begin
         n_err = n_err + 1; $display("FAIL reset_anode8 got=%b exp=00000000", anode8);
      end
      if (sel8 !== 3'd0) begin
         n_err = n_err + 1; $display("FAIL reset_sel8 got=%0d exp=0", sel8);
      end
      if (fs8 !== 1'b0) begin
         n_err = n_err + 1; $display("FAIL reset_fs8 got=%b exp=0", fs8);
      end
   endtask

   task automatic test_full_brightness();
      restart(4'd15, 4'b1111);
      run_scan(0, 330, -1, 4'd15, 4'b1111, "full");
   endtask

   task automatic test_brightness();
      restart(4'd0, 4'b1111);
      run_scan(0, 160, -1, 4'd0, 4'b1111, "bright0");
      restart(4'd7, 4'b1111);
      run_scan(0, 160, -1, 4'd7, 4'b1111, "bright7");
      // Mid-slot change: slot 0 keeps 32 lit cycles, slot 1 gets 2.
      restart(4'd15, 4'b1111);
      run_scan(0, 120, 20, 4'd0, 4'b1111, "bright_mid");
   endtask

   task automatic test_digit_en();
      restart(4'd15, 4'b1010);
      run_scan(0, 160, -1, 4'd15, 4'b1010, "den1010");
      // Mid-ON changes take effect the next cycle.
      restart(4'd15, 4'b1111);
      run_scan(0, 61, 60, 4'd15, 4'b1000, "den_mid_a");
      run_scan(61, 99, 100, 4'd15, 4'b0100, "den_mid_b");
   endtask

   task automatic test_enable_drop();
      restart(4'd15, 4'b1111);
      run_scan(0, 100, -1, 4'd15, 4'b1111, "en_pre");
      enable = 1'b0;                 // takes effect at slot 2, cnt 20
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         n_vec = n_vec + 3;
         if (anode4 !== 4'hF) begin
            n_err = n_err + 1; $display("FAIL en_drop anode j=%0d got=%b exp=1111", j, anode4);
         end
         if (sel4 !== 2'd0) begin
            n_err = n_err + 1; $display("FAIL en_drop digit_sel j=%0d got=%0d exp=0", j, sel4);
         end
         if (fs4 !== 1'b0) begin
            n_err = n_err + 1; $display("FAIL en_drop frame_start j=%0d got=%b exp=0", j, fs4);
         end
      end
      enable = 1'b1;
      @(negedge clk);
      run_scan(0, 50, -1, 4'd15, 4'b1111, "en_restart");
   endtask

   task automatic test_async_reset();
      restart(4'd15, 4'b1111);
      run_scan(0, 50, -1, 4'd15, 4'b1111, "rst_pre");   // now in slot 1 ON
      #2 rst = 1'b1;
      #1;
      n_vec = n_vec + 3;
      if (anode4 !== 4'hF) begin
         n_err = n_err + 1; $display("FAIL async_rst anode got=%b exp=1111", anode4);
      end
      if (sel4 !== 2'd0) begin
         n_err = n_err + 1; $display("FAIL async_rst digit_sel got=%0d exp=0", sel4);
      end
      if (anode8 !== 8'h00) begin
         n_err = n_err + 1; $display("FAIL async_rst anode8 got=%b exp=00000000", anode8);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_scan(0, 50, -1, 4'd15, 4'b1111, "rst_post");
   endtask

   task automatic test_active_high();
      int s;
      int k;
      logic [7:0] ea;
      restart(4'd15, 4'b1111);
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         s  = (i / 24) % 8;
         k  = i % 24;
         ea = (k >= 4 && k < 20) ? (8'b0000_0001 << s) : 8'h00;
         n_vec = n_vec + 3;
         if (anode8 !== ea) begin
            n_err = n_err + 1; $display("FAIL ah anode8 cyc=%0d got=%b exp=%b", i, anode8, ea);
         end
         if (sel8 !== 3'(s)) begin
            n_err = n_err + 1; $display("FAIL ah digit_sel8 cyc=%0d got=%0d exp=%0d", i, sel8, s);
         end
         if (fs8 !== (i % 192 == 0)) begin
            n_err = n_err + 1; $display("FAIL ah frame_start8 cyc=%0d got=%b exp=%b", i, fs8, (i % 192 == 0));
         end
      end
   endtask

   initial begin
      rst        = 1'b1;
      enable     = 1'b0;
      digit_en   = 4'b1111;
      digit_en8  = 8'hFF;
      brightness = 4'd15;
      @(negedge clk);
      @(negedge clk);
      test_reset();
      rst = 1'b0;
      @(negedge clk);
      test_full_brightness();
      test_brightness();
      test_digit_en();
      test_enable_drop();
      test_async_reset();
      test_active_high();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
